// File: rtl/conv2d_q17_pkg.sv
// Shared types and constants for the Q1.7 3x3 RGB convolution sequencer.
// Holds the FSM encoding and the tap index -> (ky, kx, ch) decode.
package conv2d_q17_pkg;

  localparam int unsigned KSIZE    = 3;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned TAPS     = KSIZE * KSIZE * CHANNELS;
  localparam int unsigned TAPW     = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_e;

  typedef struct packed {
    logic [1:0] ky;
    logic [1:0] kx;
    logic [1:0] ch;
  } tap_pos_t;

  // Kernel row layout is (ky*3 + kx)*3 + ch.
  function automatic tap_pos_t tap_decode(input logic [TAPW-1:0] tap);
    tap_pos_t pos;
    pos.ky = 2'(tap / TAPW'(KSIZE * CHANNELS));
    pos.kx = 2'((tap / TAPW'(CHANNELS)) % TAPW'(KSIZE));
    pos.ch = 2'(tap % TAPW'(CHANNELS));
    return pos;
  endfunction

endpackage

// File: rtl/conv2d_q17_tap_gen.sv
// Tap counter and same-padding coordinate generator for one output pixel.
// Outputs are registered from the look-ahead tap so they line up with the FSM state.
module conv2d_q17_tap_gen
  import conv2d_q17_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 32,
  localparam int unsigned RW    = $clog2(HEIGHT),
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic [RW-1:0]   row_i,
  input  logic [CW-1:0]   col_i,
  output logic            tap_last_o,
  output logic            img_rd_en_o,
  output logic            pad_zero_o,
  output logic [RW-1:0]   img_row_o,
  output logic [CW-1:0]   img_col_o,
  output logic [1:0]      img_ch_o,
  output logic [TAPW-1:0] k_tap_o
);

  // Two guard bits: one for the -1 offset, one so row+1 == HEIGHT never wraps.
  localparam int unsigned RSW = RW + 2;
  localparam int unsigned CSW = CW + 2;

  logic                  active_q;
  logic [TAPW-1:0]       tap_q, tap_d;
  tap_pos_t              pos;
  logic signed [RSW-1:0] r_s;
  logic signed [CSW-1:0] c_s;
  logic                  valid;
  logic                  rd_en_d, pad_d, last_d;
  logic [RW-1:0]         row_d;
  logic [CW-1:0]         col_d;
  logic [1:0]            ch_d;

  always_comb begin
    tap_d   = '0;
    if (run_i) begin
      tap_d = active_q ? tap_q + TAPW'(1) : '0;
    end
    pos     = tap_decode(tap_d);
    r_s     = RSW'(row_i) + RSW'(pos.ky) - RSW'(1);
    c_s     = CSW'(col_i) + CSW'(pos.kx) - CSW'(1);
    valid   = run_i && (r_s >= 0) && (r_s < $signed(RSW'(HEIGHT)))
                    && (c_s >= 0) && (c_s < $signed(CSW'(WIDTH)));
    rd_en_d = valid;
    pad_d   = run_i && !valid;
    row_d   = valid ? RW'(r_s) : '0;
    col_d   = valid ? CW'(c_s) : '0;
    ch_d    = run_i ? pos.ch : '0;
    last_d  = run_i && (tap_d == TAPW'(TAPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      tap_q       <= '0;
      tap_last_o  <= 1'b0;
      img_rd_en_o <= 1'b0;
      pad_zero_o  <= 1'b0;
      img_row_o   <= '0;
      img_col_o   <= '0;
      img_ch_o    <= '0;
      k_tap_o     <= '0;
    end else begin
      active_q    <= run_i;
      tap_q       <= tap_d;
      tap_last_o  <= last_d;
      img_rd_en_o <= rd_en_d;
      pad_zero_o  <= pad_d;
      img_row_o   <= row_d;
      img_col_o   <= col_d;
      img_ch_o    <= ch_d;
      k_tap_o     <= tap_d;
    end
  end

endmodule

// File: rtl/conv2d_q17_sched.sv
// Sequencer for the first-layer Q1.7 3x3 same-padded convolution datapath.
// Walks filter -> row -> col -> 27 taps, drains the MAC pipe, then writes each pixel.
module conv2d_q17_sched
  import conv2d_q17_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned HEIGHT  = 32,
  parameter int unsigned FILTERS = 28,
  parameter int unsigned MAC_LAT = 2,
  localparam int unsigned RW     = $clog2(HEIGHT),
  localparam int unsigned CW     = $clog2(WIDTH),
  localparam int unsigned FW     = $clog2(FILTERS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            img_rd_en,
  output logic [RW-1:0]   img_row,
  output logic [CW-1:0]   img_col,
  output logic [1:0]      img_ch,
  output logic [TAPW-1:0] k_tap,
  output logic [FW-1:0]   k_filt,
  output logic            acc_init,
  output logic            mac_en,
  output logic            pad_zero,
  output logic            out_wr,
  input  logic            out_ready,
  output logic [FW-1:0]   out_filt,
  output logic [RW-1:0]   out_row,
  output logic [CW-1:0]   out_col
);

  localparam int unsigned DW = $clog2(MAC_LAT + 1);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [FW-1:0]   filt_q, filt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            tap_last;
  logic            last_pix;
  logic            busy_d, done_d, acc_init_d, mac_en_d, out_wr_d;
  logic [FW-1:0]   k_filt_d, out_filt_d;
  logic [RW-1:0]   out_row_d;
  logic [CW-1:0]   out_col_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      filt_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filt_q  <= filt_d;
      drain_q <= drain_d;
    end
  end

  assign last_pix = (filt_q == FW'(FILTERS - 1)) && (row_q == RW'(HEIGHT - 1))
                 && (col_q == CW'(WIDTH - 1));

  // Next state and pixel/filter/drain counters; abort overrides everything.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    filt_d  = filt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_TAP;
      S_TAP: begin
        if (tap_last) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(MAC_LAT - 1)) state_d = S_WRITE;
        else                             drain_d = drain_q + DW'(1);
      end
      S_WRITE: begin
        if (out_ready) begin
          if (last_pix) begin
            state_d = S_FIN;
            row_d   = '0;
            col_d   = '0;
            filt_d  = '0;
          end else begin
            state_d = S_INIT;
            if (col_q == CW'(WIDTH - 1)) begin
              col_d = '0;
              if (row_q == RW'(HEIGHT - 1)) begin
                row_d  = '0;
                filt_d = filt_q + FW'(1);
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      filt_d  = '0;
      drain_d = '0;
    end
  end

  // Look-ahead output decode from the next state, registered below.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    acc_init_d = 1'b0;
    mac_en_d   = 1'b0;
    out_wr_d   = 1'b0;
    k_filt_d   = '0;
    out_filt_d = '0;
    out_row_d  = '0;
    out_col_d  = '0;
    case (state_d)
      S_INIT: begin
        busy_d     = 1'b1;
        acc_init_d = 1'b1;
        k_filt_d   = filt_d;
      end
      S_TAP: begin
        busy_d   = 1'b1;
        mac_en_d = 1'b1;
        k_filt_d = filt_d;
      end
      S_DRAIN: busy_d = 1'b1;
      S_WRITE: begin
        busy_d     = 1'b1;
        out_wr_d   = 1'b1;
        out_filt_d = filt_d;
        out_row_d  = row_d;
        out_col_d  = col_d;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_init <= 1'b0;
      mac_en   <= 1'b0;
      out_wr   <= 1'b0;
      k_filt   <= '0;
      out_filt <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      acc_init <= acc_init_d;
      mac_en   <= mac_en_d;
      out_wr   <= out_wr_d;
      k_filt   <= k_filt_d;
      out_filt <= out_filt_d;
      out_row  <= out_row_d;
      out_col  <= out_col_d;
    end
  end

  conv2d_q17_tap_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_tap_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (state_d == S_TAP),
    .row_i       (row_d),
    .col_i       (col_d),
    .tap_last_o  (tap_last),
    .img_rd_en_o (img_rd_en),
    .pad_zero_o  (pad_zero),
    .img_row_o   (img_row),
    .img_col_o   (img_col),
    .img_ch_o    (img_ch),
    .k_tap_o     (k_tap)
  );

endmodule
